pipe_control: RTL
=================

PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter RA_W, default 4, regfile address width (>=3).
REQ-002 SHALL have parameter SQUASH_CC, default 2, bubbles inserted after a control transfer (1..7).
REQ-003 SHALL have parameter LINK_REG, default all-ones of RA_W, jal link register address.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instr is valid this cycle.
- instr  in  16  instruction from ROM.
- branch_taken  in  1  EX compare result, meaningful only while branch=1.
- rom_rd  out  1  ROM fetch enable.
- stall  out  1  hold PC and IF register.
- id_valid  out  1  decoded outputs describe a real instruction.
- alu_cmd  out  3  ALU operation.
- op2_sel  out  1  1 = immediate/shamt operand.
- shamt_sel  out  1  1 = shamt, 0 = immediate.
- ram_rd, ram_wr  out  1 each  data memory strobes.
- wb_wr  out  1  regfile write enable.
- wb_waddr  out  RA_W  write-back address.
- wb_sel  out  1  1 = ALU/PC result, 0 = RAM data.
- save_pc  out  1  write PC+1 (jal).
- jump  out  1  unconditional transfer (j, jal, jr).
- branch  out  1  beq in EX.
- illegal  out  1  undefined opcode pulse.
- addr_rs, addr_rt  out  RA_W  combinational source addresses.
- imm  out  6  instr[5:0]; shamt out 3 instr[5:3].

Function
REQ-005 SHALL drive addr_rs = zero-extended instr[11:9] and addr_rt = zero-extended instr[8:6] combinationally.
REQ-006 SHALL register all other decode outputs, with a latency of one cycle from the instr sample.
REQ-007 SHALL decode opcode 0 (R-format, dest rd = instr[5:3]) by Fcode: 0 add 000; 1 sub 001; 2 and 101; 3 or 110; 4 slt 011; 5 sll 010 with op2_sel=shamt_sel=1; 6 srl 100 with op2_sel=shamt_sel=1; 7 jr with alu 000, jump=1, wb_wr=0.
- All R-format except jr SHALL set wb_wr=1 and wb_sel=1.
REQ-008 SHALL decode the remaining opcodes as follows; I-format destination is rt:
- 1 addi: op2_sel, wb_wr, wb_sel, alu 000.
- 3 slti: op2_sel, wb_wr, wb_sel, alu 011.
- 4 lw: op2_sel, ram_rd, wb_wr, wb_sel=0, alu 000.
- 5 sw: op2_sel, ram_wr, alu 000.
- 6 beq: branch, alu 111.
- 7 j: op2_sel, jump, alu 000.
- 8 jal: op2_sel, jump, save_pc, wb_wr, wb_sel, wb_waddr=LINK_REG, alu 000.
REQ-009 SHALL, for any other opcode, output a NOP (all strobes 0, id_valid=0) and pulse illegal=1 for one cycle.
REQ-010 SHALL implement an FSM with states RUN, STALL and SQUASH, plus a squash counter of 3 bits.
REQ-011 SHALL detect a load-use hazard in RUN when all of the following hold; it SHALL then assert stall combinationally that cycle, enter STALL, and register a bubble (NOP, id_valid=0):
- the registered op is lw;
- instr_valid=1;
- wb_waddr equals addr_rs, or equals addr_rt for R-format, sw or beq.
REQ-012 SHALL, in STALL, deassert stall, decode the held instr normally and return to RUN after one cycle.
REQ-013 SHALL enter SQUASH with counter = SQUASH_CC when, in RUN or STALL, jump=1, or branch=1 with branch_taken=1.
REQ-014 SHALL, in SQUASH, decode every incoming instr as NOP with id_valid=0 and illegal=0, decrement the counter each cycle, and return to RUN when the counter reaches 1.
REQ-015 SHALL give squash entry priority over a simultaneous hazard and suppress stall.
REQ-016 SHALL ignore branch_taken while branch=0.
REQ-017 SHALL, when instr_valid=0, register a NOP with id_valid=0 without changing the FSM state, except for the SQUASH count.
REQ-018 SHALL drive rom_rd = rom_en AND NOT stall, where rom_en is a flop set on the first clk after reset release.

Reset
REQ-019 SHALL, while rst=1, force state=RUN, counter=0, rom_en=0, and every registered output to 0 (wb_waddr=0, alu_cmd=000), regardless of clk.
REQ-020 SHALL, on reset asserted mid-stall or mid-squash, abandon the operation with no pending state surviving reset.

Verification
REQ-021 SHALL cover: release rst, feed addi (opcode 1, rs=2, rt=3, imm=5) -> rom_rd=1 after one edge; next cycle wb_wr=1, wb_waddr=3, op2_sel=1, alu_cmd=000, id_valid=1.
REQ-022 SHALL cover: lw to rt=4, then add with rs=4 -> stall=1 for exactly one cycle, one bubble, then the add decoded with wb_waddr=rd.
REQ-023 SHALL cover: jal with SQUASH_CC=2 -> wb_waddr=LINK_REG (15), save_pc=1; the next two instrs give id_valid=0; the third decodes normally.
REQ-024 SHALL cover: beq with branch_taken=0 -> no squash; beq with branch_taken=1 and a simultaneous load-use hazard -> squash wins, stall=0.
REQ-025 SHALL cover: opcode 15 -> illegal pulse, NOP; rst asserted mid-SQUASH -> all outputs 0 asynchronously, RUN after release.

Source files
------------

// File: rtl/pipe_control.sv
// pipe_control: ID-stage decoder and pipeline control for a 16-bit core.
// Decodes ROM words and handles load-use stalls and transfer squashes.
module pipe_control #(
  parameter int unsigned     RA_W      = 4,
  parameter int unsigned     SQUASH_CC = 2,
  parameter logic [RA_W-1:0] LINK_REG  = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  input  logic            branch_taken,
  output logic            rom_rd,
  output logic            stall,
  output logic            id_valid,
  output logic [2:0]      alu_cmd,
  output logic            op2_sel,
  output logic            shamt_sel,
  output logic            ram_rd,
  output logic            ram_wr,
  output logic            wb_wr,
  output logic [RA_W-1:0] wb_waddr,
  output logic            wb_sel,
  output logic            save_pc,
  output logic            jump,
  output logic            branch,
  output logic            illegal,
  output logic [RA_W-1:0] addr_rs,
  output logic [RA_W-1:0] addr_rt,
  output logic [5:0]      imm,
  output logic [2:0]      shamt
);

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_SLTI = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;

  localparam logic [2:0] SQ_INIT = 3'(SQUASH_CC);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    SQUASH
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [2:0]      alu;
    logic            op2;
    logic            shs;
    logic            mrd;
    logic            mwr;
    logic            wr;
    logic [RA_W-1:0] wa;
    logic            wsel;
    logic            spc;
    logic            jmp;
    logic            br;
    logic            ill;
    logic [5:0]      imm;
    logic [2:0]      sh;
  } dec_t;

  logic [3:0] opc;
  logic [2:0] fc;
  logic       uses_rt;
  logic       hazard;
  logic       xfer;
  logic       kill;

  dec_t   dec;
  dec_t   out_d, out_q;
  state_t state_d, state_q;
  logic [2:0] cnt_d, cnt_q;
  logic       rom_en_q;

  assign opc     = instr[15:12];
  assign fc      = instr[2:0];
  assign addr_rs = RA_W'(instr[11:9]);
  assign addr_rt = RA_W'(instr[8:6]);

  // rt is a source only for R-format, sw and beq; I-format writes it.
  assign uses_rt = (opc == OP_R) | (opc == OP_SW) | (opc == OP_BEQ);

  // Instruction in ID reads the register the pending load will write.
  assign hazard = out_q.mrd & instr_valid &
                  ((out_q.wa == addr_rs) |
                   (uses_rt & (out_q.wa == addr_rt)));

  // Control transfer resolved for the op now sitting in the output regs.
  assign xfer = out_q.jmp | (out_q.br & branch_taken);

  // Pure opcode/function decode of the incoming word.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.imm   = instr[5:0];
    dec.sh    = instr[5:3];
    unique case (opc)
      OP_R: begin
        dec.wr   = 1'b1;
        dec.wsel = 1'b1;
        dec.wa   = RA_W'(instr[5:3]);
        unique case (fc)
          3'd0: dec.alu = 3'b000;
          3'd1: dec.alu = 3'b001;
          3'd2: dec.alu = 3'b101;
          3'd3: dec.alu = 3'b110;
          3'd4: dec.alu = 3'b011;
          3'd5: begin
            dec.alu = 3'b010;
            dec.op2 = 1'b1;
            dec.shs = 1'b1;
          end
          3'd6: begin
            dec.alu = 3'b100;
            dec.op2 = 1'b1;
            dec.shs = 1'b1;
          end
          default: begin
            dec.jmp  = 1'b1;
            dec.wr   = 1'b0;
            dec.wsel = 1'b0;
            dec.wa   = '0;
          end
        endcase
      end
      OP_ADDI: begin
        dec.op2  = 1'b1;
        dec.wr   = 1'b1;
        dec.wsel = 1'b1;
        dec.wa   = addr_rt;
      end
      OP_SLTI: begin
        dec.alu  = 3'b011;
        dec.op2  = 1'b1;
        dec.wr   = 1'b1;
        dec.wsel = 1'b1;
        dec.wa   = addr_rt;
      end
      OP_LW: begin
        dec.op2 = 1'b1;
        dec.mrd = 1'b1;
        dec.wr  = 1'b1;
        dec.wa  = addr_rt;
      end
      OP_SW: begin
        dec.op2 = 1'b1;
        dec.mwr = 1'b1;
      end
      OP_BEQ: begin
        dec.alu = 3'b111;
        dec.br  = 1'b1;
      end
      OP_J: begin
        dec.op2 = 1'b1;
        dec.jmp = 1'b1;
      end
      OP_JAL: begin
        dec.op2  = 1'b1;
        dec.jmp  = 1'b1;
        dec.spc  = 1'b1;
        dec.wr   = 1'b1;
        dec.wsel = 1'b1;
        dec.wa   = LINK_REG;
      end
      default: begin
        dec.valid = 1'b0;
        dec.ill   = 1'b1;
      end
    endcase
  end

  // Next state, squash count, stall and bubble insertion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    kill    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (xfer) begin
          kill    = 1'b1;
          cnt_d   = SQ_INIT;
          state_d = (SQUASH_CC > 1) ? SQUASH : RUN;
        end else if (hazard) begin
          stall   = 1'b1;
          kill    = 1'b1;
          state_d = STALL;
        end else if (!instr_valid) begin
          kill = 1'b1;
        end
      end
      STALL: begin
        if (xfer) begin
          kill    = 1'b1;
          cnt_d   = SQ_INIT;
          state_d = (SQUASH_CC > 1) ? SQUASH : RUN;
        end else if (!instr_valid) begin
          kill = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      SQUASH: begin
        kill  = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd2) begin
          state_d = RUN;
        end
      end
      default: begin
        kill    = 1'b1;
        state_d = RUN;
      end
    endcase
    out_d = kill ? '0 : dec;
  end

  // Control state, fetch enable and the registered decode bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      rom_en_q <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rom_en_q <= 1'b1;
      out_q    <= out_d;
    end
  end

  assign rom_rd    = rom_en_q & ~stall;
  assign id_valid  = out_q.valid;
  assign alu_cmd   = out_q.alu;
  assign op2_sel   = out_q.op2;
  assign shamt_sel = out_q.shs;
  assign ram_rd    = out_q.mrd;
  assign ram_wr    = out_q.mwr;
  assign wb_wr     = out_q.wr;
  assign wb_waddr  = out_q.wa;
  assign wb_sel    = out_q.wsel;
  assign save_pc   = out_q.spc;
  assign jump      = out_q.jmp;
  assign branch    = out_q.br;
  assign illegal   = out_q.ill;
  assign imm       = out_q.imm;
  assign shamt     = out_q.sh;

endmodule
